param_seq_detector: RTL and testbench

//  Runtime-programmable serial bit-pattern detector; successor to the fixed 2-bit-state detector.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_sat_cnt.sv | 25 ++
 rtl/param_seq_detector.sv | 127 ++++++++++++
 tb/tb_param_seq_detector.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the runtime-programmable serial pattern detector.
package seq_det_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned LEN_W_DEF   = 4;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter: +1 per inc pulse, holds at all-ones, cleared by reset.
module seq_det_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial bit-pattern detector with registered match pulse.
// Define SEQ_DET_CNT_EN to add the saturating match_cnt output and its counter.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF
`ifdef SEQ_DET_CNT_EN
  ,
  parameter int unsigned CNT_W   = CNT_W_DEF
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic               armed,
  output logic               cfg_err
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_inc;
  logic               load_ok;
  logic               hit;

  always_comb begin
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
  end

  // One extra bit on the fill increment so MAX_LEN+1 cannot wrap when 2**LEN_W == MAX_LEN+1.
  assign fill_inc   = {1'b0, fill_q} + 1'b1;
  assign hist_shift = {hist_q[MAX_LEN-2:0], in_bit};
  assign load_ok    = len_legal(32'(cfg_len), MAX_LEN);
  assign hit        = (fill_inc >= {1'b0, len_q}) &&
                      ((hist_shift & len_mask) == (pat_q & len_mask));

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;

    if (cfg_load) begin
      if (load_ok) begin
        state_d = RUN;
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        hist_d  = '0;
        fill_d  = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if ((state_q == RUN) && in_valid) begin
      hist_d = hist_shift;
      fill_d = (fill_inc >= {1'b0, len_q}) ? len_q : fill_inc[LEN_W-1:0];
      if (hit) begin
        match_d = 1'b1;
        if (!ovl_q) fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign match   = match_q;
  assign armed   = (state_q == RUN);
  assign cfg_err = cfg_err_q;

`ifdef SEQ_DET_CNT_EN
  seq_det_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_sat_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match_d),
    .cnt   (match_cnt)
  );
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
// Scoreboard bench for param_seq_detector: a bit-queue reference model pushes expected outputs per cycle.
module tb_param_seq_detector;

  localparam int MAXL    = 8;
  localparam int CNT_MAX = 3;

  logic       clk;
  logic       reset;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       in_valid;
  logic       in_bit;
  logic       match;
  logic       armed;
  logic       cfg_err;
`ifdef SEQ_DET_CNT_EN
  logic [1:0] match_cnt;
`endif

  param_seq_detector #(
    .MAX_LEN(8),
    .LEN_W  (4)
`ifdef SEQ_DET_CNT_EN
    ,
    .CNT_W  (2)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .match      (match),
    .armed      (armed),
    .cfg_err    (cfg_err)
`ifdef SEQ_DET_CNT_EN
    ,
    .match_cnt  (match_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit match;
    bit err;
    bit armed;
    int cnt;
  } exp_t;

  exp_t sb[$];

  int n_cmp  = 0;
  int n_err  = 0;
  int n_hits = 0;

  bit       m_armed = 1'b0;
  bit [7:0] m_pat   = '0;
  int       m_len   = 0;
  bit       m_ovl   = 1'b0;
  bit       m_bits[$];
  int       m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit ld, input logic [7:0] pat, input int len,
                      input bit ovl, input bit v, input bit b);
    exp_t e;
    bit   hit;
    reset       = rst;
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_len     = len[3:0];
    cfg_overlap = ovl;
    in_valid    = v;
    in_bit      = b;

    e.match = 1'b0;
    e.err   = 1'b0;
    if (rst) begin
      m_armed = 1'b0;
      m_pat   = '0;
      m_len   = 0;
      m_ovl   = 1'b0;
      m_bits.delete();
      m_cnt   = 0;
    end else if (ld) begin
      if (len >= 1 && len <= MAXL) begin
        m_armed = 1'b1;
        m_pat   = pat;
        m_len   = len;
        m_ovl   = ovl;
        m_bits.delete();
      end else begin
        e.err = 1'b1;
      end
    end else if (v && m_armed) begin
      m_bits.push_back(b);
      if (m_bits.size() > MAXL) void'(m_bits.pop_front());
      if (m_bits.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
        if (hit) begin
          e.match = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
          if (!m_ovl) m_bits.delete();
        end
      end
    end
    e.armed = m_armed;
    e.cnt   = m_cnt;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (match === 1'b1) n_hits++;
    check("match",   32'(match),   32'(e.match));
    check("armed",   32'(armed),   32'(e.armed));
    check("cfg_err", 32'(cfg_err), 32'(e.err));
`ifdef SEQ_DET_CNT_EN
    check("match_cnt", 32'(match_cnt), 32'(e.cnt));
`endif
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [7:0] pat, input int len, input bit ovl);
    step(1'b0, 1'b1, pat, len, ovl, 1'b0, 1'b0);
  endtask

  task automatic do_idle();
    step(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--)
      step(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, bits[i]);
  endtask

  initial begin
    reset       = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    @(negedge clk);

    // unconfigured: bits ignored
    do_reset();
    n_hits = 0;
    feed(16'b1011, 4);
    check("idle_hits", 32'(n_hits), 32'd0);

    // overlapping 1011
    do_load(8'b1011, 4, 1'b1);
    n_hits = 0;
    feed(16'b1011011, 7);
    check("ovl_hits", 32'(n_hits), 32'd2);
`ifdef SEQ_DET_CNT_EN
    check("ovl_cnt", 32'(match_cnt), 32'd2);
`endif

    // non-overlapping 1011
    do_reset();
    do_load(8'b1011, 4, 1'b0);
    n_hits = 0;
    feed(16'b1011011011, 10);
    check("novl_hits", 32'(n_hits), 32'd2);

    // illegal lengths leave config alone
    do_load(8'b1011, 4, 1'b1);
    do_load(8'hFF, 0, 1'b0);
    do_load(8'hFF, MAXL + 1, 1'b0);
    do_load(8'hFF, 15, 1'b0);
    n_hits = 0;
    feed(16'b1011, 4);
    check("cfg_keep_hits", 32'(n_hits), 32'd1);

    // cfg_load beats concurrent in_valid
    feed(16'b101, 3);
    n_hits = 0;
    step(1'b0, 1'b1, 8'b1011, 4, 1'b1, 1'b1, 1'b1);
    feed(16'b011, 3);
    check("drop_hits_a", 32'(n_hits), 32'd0);
    feed(16'b1011, 4);
    check("drop_hits_b", 32'(n_hits), 32'd1);

    // in_valid gaps hold history
    do_load(8'b1011, 4, 1'b1);
    n_hits = 0;
    feed(16'b10, 2);
    do_idle();
    do_idle();
    feed(16'b11, 2);
    check("gap_hits", 32'(n_hits), 32'd1);

    // len=1, upper pattern bits ignored
    do_load(8'hA5, 1, 1'b1);
    n_hits = 0;
    feed(16'b1101, 4);
    check("len1_hits", 32'(n_hits), 32'd3);

    // len=MAX_LEN, no overlap
    do_load(8'hA5, MAXL, 1'b0);
    n_hits = 0;
    feed(16'hA5A5, 16);
    check("len8_hits", 32'(n_hits), 32'd2);

    // counter saturation, then reset mid-pattern
    do_reset();
    do_load(8'h01, 1, 1'b1);
    feed(16'b11111, 5);
`ifdef SEQ_DET_CNT_EN
    check("sat_cnt", 32'(match_cnt), 32'd3);
`endif
    do_load(8'b1011, 4, 1'b1);
    feed(16'b101, 3);
    do_reset();
    n_hits = 0;
    feed(16'b1011, 4);
    check("post_rst_hits", 32'(n_hits), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
